// File: rtl/majority_insert_sched.sv
// Round-robin front end plus encode engine: counts a word's bits, inserts the majority bit at INS_POS.
// Build option MAJ_SCHED_FAST_EN: combinational popcount on the accept edge instead of the serial COUNT state.
module majority_insert_sched #(
  parameter int DATA_W  = 7,
  parameter int INS_POS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  input  logic              req0_mode_i,
  output logic              req0_ready_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  input  logic              req1_mode_i,
  output logic              req1_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W:0]   out_data_o,
  output logic              out_src_o,
  input  logic              out_ready_i,
  output logic              busy_o
);

  localparam int OW = DATA_W + 1;
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [OW-1:0] LOW_MASK = OW'((1 << INS_POS) - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  function automatic logic [OW-1:0] insert_bit(input logic [DATA_W-1:0] word, input logic maj);
    logic [OW-1:0] ext;
    ext = {1'b0, word};
    return (ext & LOW_MASK) | ((ext & ~LOW_MASK) << 1'b1) | (OW'(maj) << INS_POS);
  endfunction

  // A tie never selects 1, whichever rule is active.
  function automatic logic majority(input logic [CW-1:0] ones, input logic [CW-1:0] zeros,
                                    input logic mode);
    logic res;
    if (mode) begin
      res = (ones > zeros);
    end else begin
      res = (zeros > ones);
    end
    return res;
  endfunction

`ifdef MAJ_SCHED_FAST_EN
  function automatic logic [CW-1:0] count_ones(input logic [DATA_W-1:0] word);
    logic [CW-1:0] cnt;
    cnt = {CW{1'b0}};
    for (int i = 0; i < DATA_W; i++) begin
      cnt = cnt + CW'(word[i]);
    end
    return cnt;
  endfunction
`endif

  state_e        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic          out_valid_q, out_valid_d;
  logic [OW-1:0] out_data_q, out_data_d;
  logic          out_src_q, out_src_d;

`ifdef MAJ_SCHED_FAST_EN
  logic [CW-1:0] acc_ones_s;
`else
  localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  logic [DATA_W-1:0] data_q, data_d;
  logic              mode_q, mode_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     zeros_q, zeros_d;
  logic [CW-1:0]     ones_q, ones_d;
  logic              cur_bit_s;
  logic              cur_zero_s;
  logic [CW-1:0]     zeros_inc_s;
  logic [CW-1:0]     ones_inc_s;
`endif

  logic              grant0_s;
  logic              grant1_s;
  logic              accept_s;
  logic [DATA_W-1:0] acc_data_s;
  logic              acc_mode_s;

  // Arbitration: only in IDLE; on contention the requester that did not win last time goes first.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_q == ST_IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
        grant0_s = last_grant_q;
        grant1_s = ~last_grant_q;
      end else begin
        grant0_s = req0_valid_i;
        grant1_s = req1_valid_i;
      end
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  assign accept_s     = grant0_s | grant1_s;
  assign acc_data_s   = grant1_s ? req1_data_i : req0_data_i;
  assign acc_mode_s   = grant1_s ? req1_mode_i : req0_mode_i;
  assign req0_ready_o = rst_n & grant0_s;
  assign req1_ready_o = rst_n & grant1_s;

  // Next-state and datapath update for the IDLE -> (COUNT) -> DONE sequence.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_src_d    = out_src_q;
`ifdef MAJ_SCHED_FAST_EN
    acc_ones_s   = count_ones(acc_data_s);
`else
    data_d       = data_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    zeros_d      = zeros_q;
    ones_d       = ones_q;
    cur_bit_s    = data_q[idx_q];
    cur_zero_s   = ~cur_bit_s;
    zeros_inc_s  = zeros_q + CW'(cur_zero_s);
    ones_inc_s   = ones_q + CW'(cur_bit_s);
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          last_grant_d = grant1_s;
          out_src_d    = grant1_s;
`ifdef MAJ_SCHED_FAST_EN
          out_data_d   = insert_bit(acc_data_s,
                                    majority(acc_ones_s, CW'(DATA_W) - acc_ones_s, acc_mode_s));
          state_d      = ST_DONE;
`else
          data_d       = acc_data_s;
          mode_d       = acc_mode_s;
          idx_d        = {IW{1'b0}};
          zeros_d      = {CW{1'b0}};
          ones_d       = {CW{1'b0}};
          state_d      = ST_COUNT;
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COUNT: begin
`ifdef MAJ_SCHED_FAST_EN
        state_d = ST_IDLE;
`else
        idx_d   = idx_q + IW'(1);
        zeros_d = zeros_inc_s;
        ones_d  = ones_inc_s;
        // The counts used here already include the final bit.
        if (idx_q == IW'(DATA_W - 1)) begin
          out_data_d  = insert_bit(data_q, majority(ones_inc_s, zeros_inc_s, mode_q));
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else begin
          state_d = ST_COUNT;
        end
`endif
      end
      ST_DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          state_d     = ST_DONE;
        end else if (out_ready_i) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= {OW{1'b0}};
      out_src_q    <= 1'b0;
`ifndef MAJ_SCHED_FAST_EN
      data_q       <= {DATA_W{1'b0}};
      mode_q       <= 1'b0;
      idx_q        <= {IW{1'b0}};
      zeros_q      <= {CW{1'b0}};
      ones_q       <= {CW{1'b0}};
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_src_q    <= out_src_d;
`ifndef MAJ_SCHED_FAST_EN
      data_q       <= data_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      zeros_q      <= zeros_d;
      ones_q       <= ones_d;
`endif
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_src_o   = out_src_q;
  assign busy_o      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_majority_insert_sched.sv
// Scoreboard bench for majority_insert_sched: grants predicted by a round-robin model,
// encoded words computed arithmetically from the majority rule.
module tb_majority_insert_sched;

  localparam int DW  = 7;
  localparam int INS = 3;
  localparam int OW  = DW + 1;
`ifdef MAJ_SCHED_FAST_EN
  localparam int LAT = 1;
`else
  localparam int LAT = DW;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_mode, req0_ready;
  logic          req1_valid, req1_mode, req1_ready;
  logic [DW-1:0] req0_data, req1_data;
  logic          out_valid, out_src, out_ready, busy;
  logic [OW-1:0] out_data;

  majority_insert_sched #(.DATA_W(DW), .INS_POS(INS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid_i(req0_valid), .req0_data_i(req0_data), .req0_mode_i(req0_mode),
    .req0_ready_o(req0_ready),
    .req1_valid_i(req1_valid), .req1_data_i(req1_data), .req1_mode_i(req1_mode),
    .req1_ready_o(req1_ready),
    .out_valid_o(out_valid), .out_data_o(out_data), .out_src_o(out_src),
    .out_ready_i(out_ready), .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [OW-1:0] data;
    logic          src;
    int            acc;
    int            due;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_err = 0;
  logic          pv[2];
  logic [DW-1:0] pd[2];
  logic          pm[2];
  logic [OW-1:0] pexp[2];
  logic          puse[2];
  logic          or_next;
  logic          last_g;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp_v);
    end
  endtask

  // Majority bit from counts, then splice it into the word with plain arithmetic.
  function automatic logic [OW-1:0] model_enc(input logic [DW-1:0] d, input logic m);
    int ones, zeros, b, hi, lo;
    ones  = $countones(d);
    zeros = DW - ones;
    if (m) b = (ones > zeros) ? 1 : 0;
    else   b = (zeros > ones) ? 1 : 0;
    hi = int'(d) / (2 ** INS);
    lo = int'(d) % (2 ** INS);
    return OW'(hi * (2 ** (INS + 1)) + b * (2 ** INS) + lo);
  endfunction

  task automatic new_word(input int s);
    pv[s]   = 1'b1;
    pd[s]   = DW'($urandom_range(0, (1 << DW) - 1));
    pm[s]   = 1'($urandom_range(0, 1));
    puse[s] = 1'b0;
  endtask

  // One clock: drive requests, then predict the grant (one word in flight at a time).
  task automatic step();
    int   g;
    exp_t e;
    @(posedge clk); #1;
    req0_valid = pv[0]; req0_data = pd[0]; req0_mode = pm[0];
    req1_valid = pv[1]; req1_data = pd[1]; req1_mode = pm[1];
    out_ready  = or_next;
    @(negedge clk);
    g = -1;
    if (sb.size() == 0) begin
      if (pv[0] && pv[1]) g = last_g ? 0 : 1;
      else if (pv[0])     g = 0;
      else if (pv[1])     g = 1;
    end
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    if (g >= 0) begin
      e.data = puse[g] ? pexp[g] : model_enc(pd[g], pm[g]);
      e.src  = (g == 1);
      e.acc  = cyc + 1;
      e.due  = cyc + 1 + LAT;
      sb.push_back(e);
      last_g  = (g == 1);
      pv[g]   = 1'b0;
      puse[g] = 1'b0;
    end
  endtask

  task automatic send(input int s, input logic [DW-1:0] d, input logic m, input logic [OW-1:0] x);
    int n;
    pv[s] = 1'b1; pd[s] = d; pm[s] = m; pexp[s] = x; puse[s] = 1'b1;
    n = 0;
    while ((pv[s] || sb.size() > 0) && n < 60) begin
      step();
      n++;
    end
    check("send_complete", pv[s] || (sb.size() > 0), 1'b0);
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((pv[0] || pv[1] || sb.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain", sb.size() + int'(pv[0]) + int'(pv[1]), 0);
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  initial begin
    exp_t e;
    logic act;
    logic exp_v;
    forever begin
      @(negedge clk); #1;
      if (rst_n) begin
        act   = (sb.size() > 0) && (cyc >= sb[0].acc);
        exp_v = act && (cyc >= sb[0].due);
        check("busy", busy, act);
        check("out_valid", out_valid, exp_v);
        if (out_valid && sb.size() > 0) begin
          check("out_data", out_data, sb[0].data);
          check("out_src", out_src, sb[0].src);
          if (out_ready) e = sb.pop_front();
        end
      end
    end
  end

  initial begin
    int n;
    pv[0] = 1'b0; pv[1] = 1'b0; puse[0] = 1'b0; puse[1] = 1'b0;
    pd[0] = '0; pd[1] = '0; pm[0] = 1'b0; pm[1] = 1'b0; pexp[0] = '0; pexp[1] = '0;
    or_next = 1'b1; last_g = 1'b1;
    req0_valid = 1'b1; req0_data = 7'h55; req0_mode = 1'b0;
    req1_valid = 1'b1; req1_data = 7'h2a; req1_mode = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    check("reset out_valid", out_valid, 1'b0);
    check("reset out_data", out_data, 8'h00);
    check("reset out_src", out_src, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset req0_ready", req0_ready, 1'b0);
    check("reset req1_ready", req1_ready, 1'b0);
    @(posedge clk); #3;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;

    send(0, 7'b0000001, 1'b0, 8'b00001001);
    send(1, 7'b1110111, 1'b1, 8'b11101111);
    send(1, 7'b1110111, 1'b0, 8'b11100111);

    // Both requesters permanently valid: grants must alternate.
    repeat (8 * (LAT + 3)) begin
      if (!pv[0]) new_word(0);
      if (!pv[1]) new_word(1);
      step();
    end
    pv[0] = 1'b0; pv[1] = 1'b0;
    run_until_idle(40);

    // Consumer stalls while the result waits in DONE.
    new_word(0);
    or_next = 1'b0;
    repeat (LAT + 8) step();
    or_next = 1'b1;
    run_until_idle(40);

    repeat (400) begin
      for (int i = 0; i < 2; i++) begin
        if (!pv[i] && $urandom_range(0, 3) == 0) new_word(i);
      end
      or_next = ($urandom_range(0, 3) != 0);
      step();
    end
    or_next = 1'b1;
    run_until_idle(60);

    // Reset while a word is in flight: it must vanish and req0 must win afterwards.
    new_word(0);
    or_next = 1'b0;
    n = 0;
    while (sb.size() == 0 && n < 10) begin
      step();
      n++;
    end
    check("pre-reset accept", sb.size(), 1);
    repeat (2) step();
    new_word(0);
    new_word(1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("midrst out_valid", out_valid, 1'b0);
    check("midrst busy", busy, 1'b0);
    check("midrst req0_ready", req0_ready, 1'b0);
    check("midrst req1_ready", req1_ready, 1'b0);
    sb.delete();
    last_g = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    or_next = 1'b1;
    run_until_idle(80);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
